snake_segment_scanner: RTL and testbench

SNAKE_SEGMENT_SCANNER -- requirements
Module: snake_segment_scanner

---
 rtl/snake_segment_scanner_pkg.sv | 21 ++
 rtl/snake_segment_scanner_if.sv | 19 +
 rtl/snake_segment_scanner_segment_store.sv | 71 +++++++
 rtl/snake_segment_scanner.sv | 124 ++++++++++++
 tb/tb_snake_segment_scanner.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_segment_scanner_pkg.sv
// ============================================================================
// snake_segment_scanner_pkg: shared sizing constants and scan FSM states. Rev 1.0
// ============================================================================
`default_nettype none

package snake_segment_scanner_pkg;

  localparam int MAX_LEN  = 32;
  localparam int INIT_LEN = 3;
  localparam int POS_W    = 20;
  localparam int LEN_W    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/snake_segment_scanner_if.sv
// ============================================================================
// snake_segment_scanner_if: segment index out to the mover, X/Y position back. Rev 1.0
// ============================================================================
`default_nettype none

interface snake_segment_scanner_if #(
  parameter int POS_W = 20
);

  logic [POS_W-1:0] bitNum;
  logic [POS_W-1:0] X;
  logic [POS_W-1:0] Y;

  modport master (output bitNum, input X, input Y);
  modport slave  (input bitNum, output X, output Y);

endinterface

`default_nettype wire

// File: rtl/snake_segment_scanner_segment_store.sv
// ============================================================================
// segment_store: slot array of segment positions plus registered pixel hit compare. Rev 1.0
// ============================================================================
`default_nettype none

module segment_store
  import snake_segment_scanner_pkg::*;
#(
  parameter int MAX_LEN = snake_segment_scanner_pkg::MAX_LEN,
  parameter int POS_W   = snake_segment_scanner_pkg::POS_W,
  parameter int LEN_W   = snake_segment_scanner_pkg::LEN_W,
  parameter int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [POS_W-1:0] wr_x,
  input  logic [POS_W-1:0] wr_y,
  input  logic [LEN_W-1:0] length,
  input  logic [POS_W-1:0] pixel_x,
  input  logic [POS_W-1:0] pixel_y,
  output logic             head_hit,
  output logic             body_hit
);

  logic [POS_W-1:0] r_slot_x [MAX_LEN];
  logic [POS_W-1:0] r_slot_y [MAX_LEN];
  logic [MAX_LEN-1:0] w_body_vec;
  logic               w_head;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_slot_x[i] <= '0;
        r_slot_y[i] <= '0;
      end
    end else if (we) begin
      r_slot_x[addr] <= wr_x;
      r_slot_y[addr] <= wr_y;
    end
  end

  // Slots at or above the live length keep stale data; the length gate masks them.
  generate
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
      if (i == 0) begin : g_head_slot
        assign w_body_vec[i] = 1'b0;
      end else begin : g_body_slot
        assign w_body_vec[i] = (LEN_W'(i) < length) &&
                               (r_slot_x[i] == pixel_x) &&
                               (r_slot_y[i] == pixel_y);
      end
    end
  endgenerate

  assign w_head = (r_slot_x[0] == pixel_x) && (r_slot_y[0] == pixel_y);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      head_hit <= 1'b0;
      body_hit <= 1'b0;
    end else begin
      head_hit <= w_head;
      body_hit <= |w_body_vec;
    end
  end

endmodule

`default_nettype wire

// File: rtl/snake_segment_scanner.sv
// ============================================================================
// snake_segment_scanner: per tick, walks segments 0..length-1 and latches the mover's X/Y. Rev 1.0
// ============================================================================
`default_nettype none

module snake_segment_scanner
  import snake_segment_scanner_pkg::*;
#(
  parameter int MAX_LEN  = snake_segment_scanner_pkg::MAX_LEN,
  parameter int INIT_LEN = snake_segment_scanner_pkg::INIT_LEN,
  parameter int POS_W    = snake_segment_scanner_pkg::POS_W
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     tick,
  input  logic                     grow,
  snake_segment_scanner_if.master  mover,
  input  logic [POS_W-1:0]         pixelX,
  input  logic [POS_W-1:0]         pixelY,
  output logic                     bodyHit,
  output logic                     headHit,
  output logic [LEN_W-1:0]         length,
  output logic                     busy,
  output logic                     frameDone,
  output logic                     overrun
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic             r_pend, w_pend_nxt;
  logic             r_ovr, w_ovr_nxt;
  logic             w_we;
  logic             w_last;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_len   <= LEN_W'(INIT_LEN);
      r_pend  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
      r_pend  <= w_pend_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  assign w_last = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_pend_nxt  = r_pend | grow;
    w_ovr_nxt   = r_ovr | (tick && (r_state != IDLE));
    w_we        = 1'b0;
    case (r_state)
      IDLE: begin
        w_idx_nxt = '0;
        if (tick) begin
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        w_we = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
        // A grow landing on this very cycle is folded in here too, at most one step per scan.
        if (w_pend_nxt) begin
          w_pend_nxt = 1'b0;
          if (r_len < LEN_W'(MAX_LEN)) begin
            w_len_nxt = r_len + LEN_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign mover.bitNum = POS_W'(r_idx);
  assign length       = r_len;
  assign busy         = (r_state == SCAN);
  assign frameDone    = (r_state == DONE);
  assign overrun      = r_ovr;

  segment_store #(
    .MAX_LEN (MAX_LEN),
    .POS_W   (POS_W),
    .LEN_W   (LEN_W),
    .IDX_W   (IDX_W)
  ) u_store (
    .clock    (clock),
    .resetN   (resetN),
    .we       (w_we),
    .addr     (r_idx),
    .wr_x     (mover.X),
    .wr_y     (mover.Y),
    .length   (r_len),
    .pixel_x  (pixelX),
    .pixel_y  (pixelY),
    .head_hit (headHit),
    .body_hit (bodyHit)
  );

endmodule

`default_nettype wire

// File: tb/tb_snake_segment_scanner.sv
// ============================================================================
// tb_snake_segment_scanner: directed scans with a scoreboard of expected frame ends. Rev 1.0
// ============================================================================
`default_nettype none

module tb_snake_segment_scanner;

  localparam int MAX_LEN = 32;
  localparam int POS_W   = 20;

  typedef struct {
    int latency;
    int last_idx;
  } exp_t;

  logic             clock = 1'b0;
  logic             resetN;
  logic             tick;
  logic             grow;
  logic [POS_W-1:0] pixelX;
  logic [POS_W-1:0] pixelY;
  logic             bodyHit;
  logic             headHit;
  logic [5:0]       length;
  logic             busy;
  logic             frameDone;
  logic             overrun;

  logic [POS_W-1:0] mx [MAX_LEN];
  logic [POS_W-1:0] my [MAX_LEN];

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fd_count = 0;
  int   model_len = 3;
  bit   model_pending = 0;
  bit   expect_overrun = 0;

  snake_segment_scanner_if #(.POS_W(POS_W)) mif ();

  // Zero-latency mover: returns the table entry for the requested segment.
  assign mif.X = mx[mif.bitNum[4:0]];
  assign mif.Y = my[mif.bitNum[4:0]];

  snake_segment_scanner #(
    .MAX_LEN  (MAX_LEN),
    .INIT_LEN (3),
    .POS_W    (POS_W)
  ) dut (
    .clock     (clock),
    .resetN    (resetN),
    .tick      (tick),
    .grow      (grow),
    .mover     (mif.master),
    .pixelX    (pixelX),
    .pixelY    (pixelY),
    .bodyHit   (bodyHit),
    .headHit   (headHit),
    .length    (length),
    .busy      (busy),
    .frameDone (frameDone),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frameDone === 1'b1) fd_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scan(input int grow_a, input int grow_b, input int tick2_at);
    int   cyc;
    int   fd0;
    int   last_bn;
    bit   seen;
    exp_t e;
    e.latency  = model_len + 1;
    e.last_idx = model_len - 1;
    sb_q.push_back(e);
    fd0     = fd_count;
    tick    = 1'b1;
    @(negedge clock);
    tick    = 1'b0;
    cyc     = 1;
    seen    = 0;
    last_bn = -1;
    while (!seen && cyc <= MAX_LEN + 4) begin
      if (frameDone === 1'b1) begin
        seen = 1;
        e = sb_q.pop_front();
        check("done_latency", cyc, e.latency);
        check("last_bitnum", last_bn, e.last_idx);
        check("done_bitnum", mif.bitNum, 0);
        check("done_busy", busy, 0);
      end else begin
        check("scan_busy", busy, 1);
        check("scan_bitnum", mif.bitNum, cyc - 1);
        last_bn = int'(mif.bitNum);
      end
      grow = (cyc == grow_a) || (cyc == grow_b);
      tick = (cyc == tick2_at);
      if (grow) model_pending = 1;
      if (tick) expect_overrun = 1;
      @(negedge clock);
      grow = 1'b0;
      tick = 1'b0;
      cyc++;
    end
    if (!seen) check("done_timeout", 0, 1);
    if (model_pending) begin
      if (model_len < MAX_LEN) model_len++;
      model_pending = 0;
    end
    check("length", length, model_len);
    check("pulse_count", fd_count - fd0, 1);
    check("overrun", overrun, expect_overrun);
  endtask

  task automatic set_pixel_and_check(input string tag, input int px, input int py,
                                     input bit exp_head, input bit exp_body);
    pixelX = POS_W'(px);
    pixelY = POS_W'(py);
    @(negedge clock);
    check({tag, "_head"}, headHit, exp_head);
    check({tag, "_body"}, bodyHit, exp_body);
  endtask

  initial begin
    int fd0;
    int guard;
    for (int i = 0; i < MAX_LEN; i++) begin
      mx[i] = POS_W'(i);
      my[i] = POS_W'(i);
    end
    resetN = 1'b0;
    tick   = 1'b0;
    grow   = 1'b0;
    pixelX = '0;
    pixelY = '0;
    @(negedge clock);
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_length", length, 3);
    check("rst_bitnum", mif.bitNum, 0);
    check("rst_framedone", frameDone, 0);
    check("rst_overrun", overrun, 0);
    check("rst_headhit", headHit, 0);
    check("rst_bodyhit", bodyHit, 0);
    resetN = 1'b1;

    // All slots cleared by reset: pixel (0,0) sits on every live slot.
    set_pixel_and_check("zero_slots", 0, 0, 1, 1);
    set_pixel_and_check("off_pixel", 7, 7, 0, 0);

    scan(0, 0, 0);
    set_pixel_and_check("slot1", 1, 1, 0, 1);
    set_pixel_and_check("slot0", 0, 0, 1, 0);
    set_pixel_and_check("slot3_unused", 3, 3, 0, 0);

    scan(2, 3, 0);
    scan(0, 0, 0);
    set_pixel_and_check("slot3_live", 3, 3, 0, 1);

    scan(0, 0, 2);
    check("overrun_sticky_idle", overrun, 1);

    scan(0, 0, 5);
    scan(5, 0, 0);

    mx[0] = POS_W'(368);
    my[0] = POS_W'(215200);
    mx[2] = POS_W'(500);
    my[2] = POS_W'(77);
    scan(0, 0, 0);
    set_pixel_and_check("far", 9999, 9999, 0, 0);
    pixelX = POS_W'(368);
    pixelY = POS_W'(215200);
    #1;
    check("head_not_yet", headHit, 0);
    @(negedge clock);
    check("head_hit", headHit, 1);
    check("head_body", bodyHit, 0);
    set_pixel_and_check("slot2_body", 500, 77, 0, 1);
    set_pixel_and_check("mixed_xy", 368, 77, 0, 0);
    mx[0] = POS_W'(1234);
    set_pixel_and_check("live_xy_ignored", 1234, 215200, 0, 0);
    pixelX = '0;
    pixelY = POS_W'(1);

    for (int n = 0; n < 32; n++) begin
      grow = 1'b1;
      model_pending = 1;
      @(negedge clock);
      grow = 1'b0;
      scan(0, 0, 0);
    end
    check("saturated_length", length, 32);
    scan(0, 0, 0);

    fd0   = fd_count;
    tick  = 1'b1;
    @(negedge clock);
    tick  = 1'b0;
    guard = 0;
    while (mif.bitNum !== POS_W'(1) && guard < 8) begin
      @(negedge clock);
      guard++;
    end
    check("midscan_idx", mif.bitNum, 1);
    resetN = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_length", length, 3);
    check("midrst_bitnum", mif.bitNum, 0);
    check("midrst_framedone", frameDone, 0);
    check("midrst_overrun", overrun, 0);
    repeat (3) @(negedge clock);
    check("midrst_no_pulse", fd_count - fd0, 0);
    resetN = 1'b1;
    model_len      = 3;
    model_pending  = 0;
    expect_overrun = 0;
    set_pixel_and_check("post_rst_head", 0, 0, 1, 1);
    scan(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
